fb_port_arbiter: RTL and testbench

Shares one single-port framebuffer RAM between three requesters: display scan-out (pixel fetch), a drawing engine (write handshake) and a built-in frame-clear sequencer. Sits between the VGA timing/scan-out logic and the framebuffer RAM. Scan-out has absolute priority because it must meet a fixed-latency pixel deadline. The clear sequencer and the drawing engine use the remaining RAM cycles.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_clear_sweep.sv | 27 ++
 rtl/fb_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_fb_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer port arbiter.
// Geometry, pixel word type and clear-sequencer state encoding.
package fb_pkg;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 12;
  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int PIX_LAT  = 3;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  typedef logic [DATA_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CLEAR
  } clear_state_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return addr <= LAST_ADDR;
  endfunction

endpackage

// File: rtl/fb_clear_sweep.sv
// Address counter for the frame-clear sequencer.
// Advances one word per granted clear write; restart returns it to word 0.
module fb_clear_sweep
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  // Restart wins over advance so the terminal write leaves the counter at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr <= '0;
    end else if (restart) begin
      addr <= '0;
    end else if (advance) begin
      addr <= addr + 1'b1;
    end
  end

  assign last = (addr == LAST_ADDR);

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads first, then the frame-clear
// sweep, then drawing-engine writes; one registered RAM access per cycle.
module fb_port_arbiter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rvalid,
  output logic [DATA_W-1:0] pix_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  input  logic              frame_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  clear_state_t      state;
  clear_state_t      state_next;
  pixel_t            color_q;
  logic [ADDR_W-1:0] sweep_addr;
  logic              sweep_last;
  logic              clear_grant;
  logic              clear_final;
  logic              wr_fire;
  logic              pix_hit;
  logic              en_next;
  logic              we_next;
  logic [ADDR_W-1:0] addr_next;
  pixel_t            wdata_next;
  logic              s1_valid;
  logic              s1_oor;
  logic              s2_valid;
  logic              s2_oor;

  assign clear_grant = !pix_req && (state == CLEAR);
  assign clear_final = clear_grant && sweep_last;
  assign wr_ready    = reset && !pix_req && (state != CLEAR);
  assign wr_fire     = wr_valid && wr_ready;
  assign pix_hit     = pix_req && in_range(pix_addr);
  assign clear_busy  = (state != IDLE);

  fb_clear_sweep u_sweep (
    .clk     (clk),
    .reset   (reset),
    .advance (clear_grant && !sweep_last),
    .restart (clear_final),
    .addr    (sweep_addr),
    .last    (sweep_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      color_q <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && clear_start) begin
        color_q <= clear_color;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_start) state_next = ARMED;
      ARMED:   if (frame_start) state_next = CLEAR;
      CLEAR:   if (clear_final) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // An out-of-range pixel request still owns the slot, so nothing else is issued.
  always_comb begin
    en_next    = 1'b0;
    we_next    = 1'b0;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    if (pix_req) begin
      en_next = pix_hit;
      if (pix_hit) begin
        addr_next = pix_addr;
      end
    end else if (clear_grant) begin
      en_next    = 1'b1;
      we_next    = 1'b1;
      addr_next  = sweep_addr;
      wdata_next = color_q;
    end else if (wr_fire && in_range(wr_addr)) begin
      en_next    = 1'b1;
      we_next    = 1'b1;
      addr_next  = wr_addr;
      wdata_next = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      clear_done <= 1'b0;
    end else begin
      mem_en     <= en_next;
      mem_we     <= we_next;
      mem_addr   <= addr_next;
      mem_wdata  <= wdata_next;
      clear_done <= clear_final;
    end
  end

  // Fixed three-stage read pipeline; RAM data arrives while stage 2 is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid   <= 1'b0;
      s1_oor     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_oor     <= 1'b0;
      pix_rvalid <= 1'b0;
      pix_rdata  <= '0;
    end else begin
      s1_valid   <= pix_req;
      s1_oor     <= pix_req && !pix_hit;
      s2_valid   <= s1_valid;
      s2_oor     <= s1_oor;
      pix_rvalid <= s2_valid;
      pix_rdata  <= (s2_valid && !s2_oor) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter with a read-returns-addr+1 RAM model.
module tb_fb_port_arbiter;
  import fb_pkg::*;

  logic              clk;
  logic              reset;
  logic              pix_req;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_rvalid;
  logic [DATA_W-1:0] pix_rdata;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              frame_start;
  logic              clear_busy;
  logic              clear_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  fb_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pix_req     (pix_req),
    .pix_addr    (pix_addr),
    .pix_rvalid  (pix_rvalid),
    .pix_rdata   (pix_rdata),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .frame_start (frame_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= pixel_t'(mem_addr + 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_req     = 1'b0;
    pix_addr    = '0;
    wr_valid    = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    clear_start = 1'b0;
    clear_color = '0;
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [44:0] obs;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_req     = 1'($urandom);
      pix_addr    = ADDR_W'($urandom);
      wr_valid    = 1'($urandom);
      wr_addr     = ADDR_W'($urandom);
      wr_data     = DATA_W'($urandom);
      clear_start = 1'($urandom);
      clear_color = DATA_W'($urandom);
      frame_start = 1'($urandom);
      step();
      obs = {pix_rvalid, pix_rdata, wr_ready, clear_busy, clear_done,
             mem_en, mem_we, mem_addr, mem_wdata};
      checks++;
      if (obs !== '0) begin
        failures++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %h expected 0", i, obs);
      end
    end
    idle_inputs();
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(5);
    wr_data  = 12'h123;
    reset    = 1'b1;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(5) || mem_wdata !== 12'h123) begin
      failures++;
      $display("[TB] FAIL first_write: got en=%b we=%b addr=%h data=%h expected 1 1 0005 123",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    step();
  endtask

  task automatic test_pixel_latency();
    logic   exp_en;
    logic   exp_rv;
    pixel_t exp_data;
    for (int j = 0; j < 8; j++) begin
      pix_req  = (j < 4);
      pix_addr = ADDR_W'(16 + j);
      step();
      exp_en = (j < 4);
      checks++;
      if (mem_en !== exp_en || mem_we !== 1'b0 || (exp_en && mem_addr !== ADDR_W'(16 + j))) begin
        failures++;
        $display("[TB] FAIL pix_issue step %0d: got en=%b we=%b addr=%h expected en=%b addr=%h",
                 j, mem_en, mem_we, mem_addr, exp_en, ADDR_W'(16 + j));
      end
      exp_rv   = (j >= PIX_LAT - 1) && (j <= PIX_LAT + 2);
      exp_data = pixel_t'(15 + j);
      checks++;
      if (pix_rvalid !== exp_rv || (exp_rv && pix_rdata !== exp_data)) begin
        failures++;
        $display("[TB] FAIL pix_return step %0d: got v=%b d=%h expected v=%b d=%h",
                 j, pix_rvalid, pix_rdata, exp_rv, exp_data);
      end
    end
  endtask

  task automatic test_writer_stall();
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(16'h0100);
    wr_data  = 12'hABC;
    pix_addr = ADDR_W'(16'h0020);
    for (int i = 0; i < 8; i++) begin
      pix_req = 1'b1;
      #1;
      checks++;
      if (wr_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_ready cycle %0d: got %b expected 0", i, wr_ready);
      end
      step();
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("[TB] FAIL stall_we cycle %0d: got %b expected 0", i, mem_we);
      end
    end
    pix_req = 1'b0;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL unstall_ready: got %b expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== ADDR_W'(16'h0100) || mem_wdata !== 12'hABC) begin
      failures++;
      $display("[TB] FAIL unstall_write: got en=%b we=%b addr=%h data=%h expected 1 1 0100 abc",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    repeat (4) step();
  endtask

  task automatic test_out_of_range();
    pix_req  = 1'b1;
    pix_addr = ADDR_W'(FB_DEPTH);
    step();
    pix_req = 1'b0;
    checks++;
    if (mem_en !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oor_pix_en: got %b expected 0", mem_en);
    end
    step();
    checks++;
    if (pix_rvalid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oor_pix_early: got %b expected 0", pix_rvalid);
    end
    step();
    checks++;
    if (pix_rvalid !== 1'b1 || pix_rdata !== 12'h000) begin
      failures++;
      $display("[TB] FAIL oor_pix_return: got v=%b d=%h expected v=1 d=000", pix_rvalid, pix_rdata);
    end
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(16'h7FFF);
    wr_data  = 12'h777;
    #1;
    checks++;
    if (wr_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL oor_wr_ready: got %b expected 1", wr_ready);
    end
    step();
    wr_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL oor_wr_drop: got en=%b we=%b expected 0 0", mem_en, mem_we);
    end
    step();
  endtask

  task automatic test_clear();
    int   armed_we;
    int   we_count;
    int   bad;
    int   done_count;
    int   done_bad;
    int   busy_cycles;
    int   idle_run;
    int   exp_addr;
    logic p;
    clear_color = 12'h0F0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    clear_color = '0;
    checks++;
    if (clear_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL armed_busy: got %b expected 1", clear_busy);
    end
    armed_we = 0;
    for (int i = 0; i < 10; i++) begin
      clear_start = (i == 3);
      clear_color = (i == 3) ? 12'h00F : 12'h000;
      step();
      if (mem_we === 1'b1 || clear_busy !== 1'b1) armed_we++;
    end
    clear_start = 1'b0;
    checks++;
    if (armed_we !== 0) begin
      failures++;
      $display("[TB] FAIL armed_quiet: got %0d bad cycles expected 0", armed_we);
    end
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    we_count = 0; bad = 0; done_count = 0; done_bad = 0;
    busy_cycles = 0; idle_run = 0; exp_addr = 0; p = 1'b1;
    for (int i = 0; i < 40000 && idle_run < 4; i++) begin
      if (mem_we === 1'b1) begin
        if (mem_addr !== ADDR_W'(exp_addr) || mem_wdata !== 12'h0F0) bad++;
        exp_addr++;
        we_count++;
      end
      if (clear_done === 1'b1) begin
        done_count++;
        if (clear_busy !== 1'b0) done_bad++;
      end
      if (clear_busy === 1'b1) busy_cycles++;
      else idle_run++;
      wr_valid = clear_busy;
      wr_addr  = ADDR_W'(16'h0200);
      wr_data  = 12'h555;
      pix_req  = p;
      pix_addr = ADDR_W'(16'h0040);
      p = !p;
      step();
    end
    pix_req  = 1'b0;
    wr_valid = 1'b0;
    checks++;
    if (we_count !== FB_DEPTH) begin
      failures++;
      $display("[TB] FAIL clear_write_count: got %0d expected %0d", we_count, FB_DEPTH);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL clear_write_content: got %0d wrong writes expected 0", bad);
    end
    checks++;
    if (busy_cycles < 2 * FB_DEPTH - 1 || busy_cycles > 2 * FB_DEPTH + 1) begin
      failures++;
      $display("[TB] FAIL clear_duration: got %0d expected %0d +-1", busy_cycles, 2 * FB_DEPTH);
    end
    checks++;
    if (done_count !== 1 || done_bad !== 0) begin
      failures++;
      $display("[TB] FAIL clear_done_pulse: got %0d pulses (%0d while busy) expected 1 (0)",
               done_count, done_bad);
    end
    repeat (4) step();
  endtask

  task automatic test_reset_mid_clear();
    logic [44:0] obs;
    logic        found;
    int          stray;
    logic        got_first;
    clear_color = 12'h00F;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      if (mem_we === 1'b1 && mem_addr === ADDR_W'(5000)) found = 1'b1;
      else step();
    end
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_clear_reach: got found=%b expected 1", found);
    end
    pix_req  = 1'b1;
    pix_addr = ADDR_W'(16'h0030);
    step();
    pix_req = 1'b0;
    reset   = 1'b0;
    #1;
    obs = {pix_rvalid, pix_rdata, wr_ready, clear_busy, clear_done,
           mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("[TB] FAIL mid_clear_reset: got %h expected 0", obs);
    end
    step();
    step();
    reset = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pix_rvalid !== 1'b0 || clear_done !== 1'b0 || clear_busy !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("[TB] FAIL post_reset_quiet: got %0d stray cycles expected 0", stray);
    end
    clear_color = 12'h00F;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    got_first = 1'b0;
    for (int i = 0; i < 10 && !got_first; i++) begin
      if (mem_we === 1'b1) got_first = 1'b1;
      else step();
    end
    checks++;
    if (got_first !== 1'b1 || mem_addr !== '0 || mem_wdata !== 12'h00F) begin
      failures++;
      $display("[TB] FAIL restart_addr: got seen=%b addr=%h data=%h expected 1 0000 00f",
               got_first, mem_addr, mem_wdata);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    #2;
    test_reset();
    test_pixel_latency();
    test_writer_stall();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
